// File: rtl/branch_pred_unit_pkg.sv
// ============================================================================
// Module      : branch_pred_unit_pkg
// Description : Shared branch codes, opcode macros and 2-bit counter helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif

package branch_pred_unit_pkg;

   localparam int BPU_ENTRIES = 64;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_RESET = 2'b01;
   localparam ctr_t CTR_ALLOC = 2'b10;

   // Saturating step of a 2-bit direction counter.
   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      if (taken && (c != 2'b11))
         n = c + 2'b01;
      else if (!taken && (c != 2'b00))
         n = c - 2'b01;
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cmp.sv
// ============================================================================
// Module      : branch_cmp
// Description : Combinational B-type condition evaluation (op1 vs op2 by funct3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cmp
   import branch_pred_unit_pkg::*;
(
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic [2:0]  funct3,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = (op1 == op2);
         F3_BNE:  taken = (op1 != op2);
         F3_BLT:  taken = ($signed(op1) <  $signed(op2));
         F3_BGE:  taken = ($signed(op1) >= $signed(op2));
         F3_BLTU: taken = (op1 <  op2);
         F3_BGEU: taken = (op1 >= op2);
         default: taken = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_pred_unit.sv
// ============================================================================
// Module      : branch_pred_unit
// Description : Direct-mapped BTB + 2-bit counters with decode-stage branch
//               resolution. Define BPU_TAGS_EN to add per-entry tag matching.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif

module branch_pred_unit
   import branch_pred_unit_pkg::*;
#(
   parameter int ENTRIES = BPU_ENTRIES,
   parameter int TAGW    = 8
)
(
   input  logic                      clk,
   input  logic                      nrst,
   input  logic [31:0]               fetch_pc,
   output logic                      pred_taken,
   output logic [31:0]               pred_target,
   input  logic                      stall,
   input  logic                      dec_valid,
   input  logic [31:0]               dec_pc,
   input  logic [`OPCODE_SIZE-1:0]   opcode,
   input  logic [2:0]                funct3,
   input  logic [31:0]               imm,
   input  logic [31:0]               rs1_rf,
   input  logic [31:0]               rs2_rf,
   input  logic [31:0]               fw_data,
   input  logic                      br_fwsel1,
   input  logic                      br_fwsel2,
   output logic                      br_taken,
   output logic                      mispredict,
   output logic [31:0]               correct_pc
);

   localparam int IDXW = $clog2(ENTRIES);

   logic        r_valid  [ENTRIES];
   ctr_t        r_ctr    [ENTRIES];
   logic [31:0] r_target [ENTRIES];

   logic        r_pd_taken;
   logic [31:0] r_pd_target;

   logic [IDXW-1:0] w_fidx;
   logic [IDXW-1:0] w_didx;
   logic            w_fhit;
   logic            w_dhit;
   logic            w_unused_pc;

   assign w_fidx      = fetch_pc[IDXW+1:2];
   assign w_didx      = dec_pc[IDXW+1:2];
   assign w_unused_pc = ^{fetch_pc[31:IDXW+2], fetch_pc[1:0]};

`ifdef BPU_TAGS_EN
   logic [TAGW-1:0] r_tag [ENTRIES];
   logic [TAGW-1:0] w_ftag;
   logic [TAGW-1:0] w_dtag;

   assign w_ftag = fetch_pc[IDXW+TAGW+1:IDXW+2];
   assign w_dtag = dec_pc[IDXW+TAGW+1:IDXW+2];
   assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
   assign w_dhit = r_valid[w_didx] && (r_tag[w_didx] == w_dtag);
`else
   localparam int c_unused_tagw = TAGW;

   // Untagged: any valid entry hits; aliases are caught by the mispredict path.
   assign w_fhit = r_valid[w_fidx];
   assign w_dhit = r_valid[w_didx];
`endif

   logic        w_pred_taken;
   logic        w_res;
   logic        w_is_br;
   logic        w_cmp_taken;
   logic        w_br_taken;
   logic        w_alias;
   logic        w_mispredict;
   logic [31:0] w_op1;
   logic [31:0] w_op2;
   logic [31:0] w_act_tgt;
   logic [31:0] w_seq_pc;

   assign w_pred_taken = w_fhit && r_ctr[w_fidx][1];

   assign w_res     = dec_valid && !stall;
   assign w_op1     = br_fwsel1 ? fw_data : rs1_rf;
   assign w_op2     = br_fwsel2 ? fw_data : rs2_rf;
   assign w_is_br   = w_res && (opcode == `BTYPE_OP);
   assign w_act_tgt = dec_pc + imm;
   assign w_seq_pc  = dec_pc + 32'd4;

   branch_cmp u_cmp (
      .op1    (w_op1),
      .op2    (w_op2),
      .funct3 (funct3),
      .taken  (w_cmp_taken)
   );

   assign w_br_taken   = w_is_br && w_cmp_taken;
   assign w_alias      = w_res && !w_is_br && r_pd_taken;
   assign w_mispredict = (w_is_br && ((w_cmp_taken != r_pd_taken) ||
                                      (w_cmp_taken && (r_pd_target != w_act_tgt))))
                         || w_alias;

   assign pred_taken  = nrst && w_pred_taken;
   assign pred_target = pred_taken ? r_target[w_fidx] : 32'd0;
   assign br_taken    = nrst && w_br_taken;
   assign mispredict  = nrst && w_mispredict;
   assign correct_pc  = !nrst ? 32'd0 : (w_br_taken ? w_act_tgt : w_seq_pc);

   // F/D register; a redirect squashes the slot fetched alongside it.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_pd_taken  <= 1'b0;
         r_pd_target <= 32'd0;
      end else if (stall) begin
         r_pd_taken  <= r_pd_taken;
         r_pd_target <= r_pd_target;
      end else if (w_mispredict) begin
         r_pd_taken  <= 1'b0;
         r_pd_target <= 32'd0;
      end else begin
         r_pd_taken  <= w_pred_taken;
         r_pd_target <= w_pred_taken ? r_target[w_fidx] : 32'd0;
      end
   end

   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic w_sel;
      assign w_sel = (w_didx == IDXW'(gi));

      always_ff @(posedge clk) begin
         if (!nrst) begin
            r_valid[gi] <= 1'b0;
            r_ctr[gi]   <= CTR_RESET;
         end else if (w_is_br && w_sel) begin
            if (w_cmp_taken && !w_dhit) begin
               r_valid[gi]  <= 1'b1;
               r_ctr[gi]    <= CTR_ALLOC;
               r_target[gi] <= w_act_tgt;
`ifdef BPU_TAGS_EN
               r_tag[gi]    <= w_dtag;
`endif
            end else begin
               r_ctr[gi] <= ctr_next(r_ctr[gi], w_cmp_taken);
            end
         end else if (w_alias && w_sel) begin
            r_valid[gi] <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_branch_pred_unit.sv
// ============================================================================
// Module      : tb_branch_pred_unit
// Description : Directed self-checking bench for branch_pred_unit (untagged build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif

module tb_branch_pred_unit;

   localparam logic [`OPCODE_SIZE-1:0] BR_OP  = `BTYPE_OP;
   localparam logic [`OPCODE_SIZE-1:0] ALU_OP = 7'b0010011;

   logic                    clk = 1'b0;
   logic                    nrst;
   logic [31:0]             fetch_pc;
   logic                    pred_taken;
   logic [31:0]             pred_target;
   logic                    stall;
   logic                    dec_valid;
   logic [31:0]             dec_pc;
   logic [`OPCODE_SIZE-1:0] opcode;
   logic [2:0]              funct3;
   logic [31:0]             imm;
   logic [31:0]             rs1_rf;
   logic [31:0]             rs2_rf;
   logic [31:0]             fw_data;
   logic                    br_fwsel1;
   logic                    br_fwsel2;
   logic                    br_taken;
   logic                    mispredict;
   logic [31:0]             correct_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_pred_unit dut (
      .clk         (clk),
      .nrst        (nrst),
      .fetch_pc    (fetch_pc),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .stall       (stall),
      .dec_valid   (dec_valid),
      .dec_pc      (dec_pc),
      .opcode      (opcode),
      .funct3      (funct3),
      .imm         (imm),
      .rs1_rf      (rs1_rf),
      .rs2_rf      (rs2_rf),
      .fw_data     (fw_data),
      .br_fwsel1   (br_fwsel1),
      .br_fwsel2   (br_fwsel2),
      .br_taken    (br_taken),
      .mispredict  (mispredict),
      .correct_pc  (correct_pc)
   );

   task automatic set_idle();
      stall     = 1'b0;
      dec_valid = 1'b0;
      dec_pc    = 32'd0;
      opcode    = ALU_OP;
      funct3    = 3'b000;
      imm       = 32'd0;
      rs1_rf    = 32'd0;
      rs2_rf    = 32'd0;
      fw_data   = 32'd0;
      br_fwsel1 = 1'b0;
      br_fwsel2 = 1'b0;
   endtask

   task automatic set_dec(input logic [31:0] pc, input logic [`OPCODE_SIZE-1:0] op,
                          input logic [2:0] f3, input logic [31:0] im,
                          input logic [31:0] a, input logic [31:0] b);
      set_idle();
      dec_valid = 1'b1;
      dec_pc    = pc;
      opcode    = op;
      funct3    = f3;
      imm       = im;
      rs1_rf    = a;
      rs2_rf    = b;
   endtask

   // Puts pc in fetch for one edge so the F/D register holds its prediction.
   task automatic fetch_cycle(input logic [31:0] pc);
      set_idle();
      fetch_pc = pc;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      nrst     = 1'b0;
      fetch_pc = 32'h100;
      set_dec(32'h100, BR_OP, 3'b000, 32'h40, 32'd5, 32'd5);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({pred_taken, pred_target, br_taken, mispredict, correct_pc} !== 67'd0) begin
         errors++;
         $display("FAIL reset_outputs: got pt=%b ptg=%h bt=%b mp=%b cpc=%h, want all 0",
                  pred_taken, pred_target, br_taken, mispredict, correct_pc);
      end
      @(posedge clk); #1;
      nrst = 1'b1;
      set_idle();
      fetch_pc = 32'h100;
      @(negedge clk);
      checks++;
      if (pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_pred_taken: got %b want 0", pred_taken);
      end
      checks++;
      if (pred_target !== 32'd0) begin
         errors++;
         $display("FAIL reset_pred_target: got %h want 0", pred_target);
      end
      checks++;
      if (mispredict !== 1'b0) begin
         errors++;
         $display("FAIL reset_mispredict: got %b want 0", mispredict);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_cold_taken();
      fetch_cycle(32'h100);
      set_dec(32'h100, BR_OP, 3'b000, 32'h40, 32'd5, 32'd5);
      fetch_pc = 32'h100;
      @(negedge clk);
      checks++;
      if (mispredict !== 1'b1) begin
         errors++;
         $display("FAIL cold_mispredict: got %b want 1", mispredict);
      end
      checks++;
      if (correct_pc !== 32'h140) begin
         errors++;
         $display("FAIL cold_correct_pc: got %h want 00000140", correct_pc);
      end
      checks++;
      if (br_taken !== 1'b1) begin
         errors++;
         $display("FAIL cold_br_taken: got %b want 1", br_taken);
      end
      checks++;
      if (pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL no_bypass_pred: got %b want 0", pred_taken);
      end
      @(posedge clk); #1;
      set_idle();
      fetch_pc = 32'h100;
      @(negedge clk);
      checks++;
      if ({pred_taken, pred_target} !== {1'b1, 32'h140}) begin
         errors++;
         $display("FAIL alloc_pred: got pt=%b tgt=%h want pt=1 tgt=00000140",
                  pred_taken, pred_target);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_not_taken();
      for (int i = 0; i < 4; i++) begin
         fetch_cycle(32'h100);
         set_dec(32'h100, BR_OP, 3'b000, 32'h40, 32'd5, 32'd6);
         @(negedge clk);
         checks++;
         if (mispredict !== (i == 0)) begin
            errors++;
            $display("FAIL nt_mispredict[%0d]: got %b want %b", i, mispredict, (i == 0));
         end
         checks++;
         if ({br_taken, correct_pc} !== {1'b0, 32'h104}) begin
            errors++;
            $display("FAIL nt_resolve[%0d]: got bt=%b cpc=%h want bt=0 cpc=00000104",
                     i, br_taken, correct_pc);
         end
         @(posedge clk); #1;
      end
      set_idle();
      fetch_pc = 32'h100;
      @(negedge clk);
      checks++;
      if (pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL nt_final_pred: got %b want 0", pred_taken);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_forwarding();
      fetch_cycle(32'h184);
      set_dec(32'h184, BR_OP, 3'b110, 32'h20, 32'd0, 32'd5);
      fw_data   = 32'hFFFF_FFFF;
      br_fwsel2 = 1'b1;
      @(negedge clk);
      checks++;
      if ({br_taken, mispredict, correct_pc} !== {1'b1, 1'b1, 32'h1A4}) begin
         errors++;
         $display("FAIL fwd_bltu: got bt=%b mp=%b cpc=%h want bt=1 mp=1 cpc=000001a4",
                  br_taken, mispredict, correct_pc);
      end
      @(posedge clk); #1;
      fetch_cycle(32'h184);
      set_dec(32'h184, BR_OP, 3'b100, 32'h20, 32'd0, 32'd5);
      fw_data   = 32'hFFFF_FFFF;
      br_fwsel2 = 1'b1;
      @(negedge clk);
      checks++;
      if ({br_taken, mispredict, correct_pc} !== {1'b0, 1'b1, 32'h188}) begin
         errors++;
         $display("FAIL fwd_blt: got bt=%b mp=%b cpc=%h want bt=0 mp=1 cpc=00000188",
                  br_taken, mispredict, correct_pc);
      end
      @(posedge clk); #1;
      // rs1 forwarded: op1 = 0 < op2 = 1 unsigned, while regfile rs1 would say otherwise
      fetch_cycle(32'h184);
      set_dec(32'h184, BR_OP, 3'b110, 32'h20, 32'hFFFF_FFFF, 32'd1);
      fw_data   = 32'd0;
      br_fwsel1 = 1'b1;
      @(negedge clk);
      checks++;
      if ({br_taken, mispredict} !== 2'b11) begin
         errors++;
         $display("FAIL fwd_rs1: got bt=%b mp=%b want bt=1 mp=1", br_taken, mispredict);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_funct3();
      logic [2:0]  f3v [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b100};
      logic [31:0] av  [8] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd5, 32'd7};
      logic [31:0] bv  [8] = '{32'd6, 32'd6, 32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd7};
      logic        ev  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         set_dec(32'h3C8, BR_OP, f3v[i], 32'h10, av[i], bv[i]);
         @(negedge clk);
         checks++;
         if (br_taken !== ev[i]) begin
            errors++;
            $display("FAIL funct3[%0d] f3=%b: got bt=%b want %b", i, f3v[i], br_taken, ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      fetch_cycle(32'h100);
      set_dec(32'h100, BR_OP, 3'b000, 32'h40, 32'd5, 32'd5);
      stall    = 1'b1;
      fetch_pc = 32'h200;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({mispredict, br_taken} !== 2'b00) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got mp=%b bt=%b want 0 0", i, mispredict, br_taken);
         end
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(negedge clk);
      checks++;
      if ({mispredict, correct_pc} !== {1'b1, 32'h140}) begin
         errors++;
         $display("FAIL stall_release: got mp=%b cpc=%h want mp=1 cpc=00000140",
                  mispredict, correct_pc);
      end
      @(posedge clk); #1;
      // counter 00 -> 01 from a single update: still predicts not-taken
      set_idle();
      fetch_pc = 32'h100;
      @(negedge clk);
      checks++;
      if (pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL stall_single_update: got pt=%b want 0", pred_taken);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alias();
      fetch_cycle(32'h100);
      set_dec(32'h100, BR_OP, 3'b000, 32'h40, 32'd5, 32'd5);
      @(negedge clk);
      checks++;
      if (mispredict !== 1'b1) begin
         errors++;
         $display("FAIL alias_setup: got mp=%b want 1", mispredict);
      end
      @(posedge clk); #1;
      set_idle();
      fetch_pc = 32'h200;
      @(negedge clk);
      checks++;
      if ({pred_taken, pred_target} !== {1'b1, 32'h140}) begin
         errors++;
         $display("FAIL alias_pred: got pt=%b tgt=%h want pt=1 tgt=00000140",
                  pred_taken, pred_target);
      end
      @(posedge clk); #1;
      set_dec(32'h200, ALU_OP, 3'b000, 32'd0, 32'd5, 32'd5);
      @(negedge clk);
      checks++;
      if ({mispredict, br_taken, correct_pc} !== {1'b1, 1'b0, 32'h204}) begin
         errors++;
         $display("FAIL alias_redirect: got mp=%b bt=%b cpc=%h want mp=1 bt=0 cpc=00000204",
                  mispredict, br_taken, correct_pc);
      end
      @(posedge clk); #1;
      set_idle();
      fetch_pc = 32'h100;
      @(negedge clk);
      checks++;
      if (pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL alias_invalidated: got pt=%b want 0", pred_taken);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle();
      nrst     = 1'b0;
      fetch_pc = 32'd0;
      test_reset();
      test_cold_taken();
      test_not_taken();
      test_forwarding();
      test_funct3();
      test_stall();
`ifndef BPU_TAGS_EN
      test_alias();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
